// File: rtl/alu_console_seq_if.sv
// ALU attachment bus for alu_console_seq: operands/opcode out to a
// combinational ALU, result and flags back.
interface alu_console_seq_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] operand1;
  logic [DATA_W-1:0] operand2;
  logic [3:0]        op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_negative;
  logic              alu_overflow;
  logic              alu_zero;

  // console side: drives the ALU inputs, observes its outputs
  modport master (
    output operand1, operand2, op,
    input  alu_result, alu_negative, alu_overflow, alu_zero
  );

  // ALU side
  modport slave (
    input  operand1, operand2, op,
    output alu_result, alu_negative, alu_overflow, alu_zero
  );
endinterface

// File: rtl/alu_console_seq.sv
// alu_console_seq: button/switch console that loads ALU operands 16 bits at
// a time, sequences one ALU operation per exec press (IDLE->ISSUE->CAPTURE->
// DONE), captures result/flags and shows result or an operand on 7-seg digits.
// Optional macro ALU_CONSOLE_DEBOUNCE_EN adds a DEB_CYCLES debounce filter
// between each button synchroniser and its edge detector.
module alu_console_seq #(
  parameter int DATA_W     = 32,
  parameter int DIGITS     = 8,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  btn_load_a,
  input  logic                  btn_load_b,
  input  logic                  btn_exec,
  input  logic                  btn_page,
  input  logic [15:0]           sw_data,
  input  logic [3:0]            sw_op,
  alu_console_seq_if.master     alu,
  output logic [DATA_W-1:0]     result_q,
  output logic [2:0]            flags_q,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            page,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int B_LA = 0, B_LB = 1, B_EX = 2, B_PG = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;

  // Illegal configurations stop elaboration rather than misbehave silently.
  if ((DATA_W % 16) != 0 || DATA_W < 16 || DATA_W > 32 ||
      DIGITS < 1 || DIGITS > DATA_W / 4 || DEB_CYCLES < 1) begin : g_bad_param
    $error("alu_console_seq: illegal DATA_W/DIGITS/DEB_CYCLES");
  end

  logic [3:0]        btn_raw;
  logic [3:0]        ev;
  state_t            state;
  logic [DATA_W-1:0] operand1, operand2, sel;
  logic [3:0]        op;

  assign btn_raw      = {btn_page, btn_exec, btn_load_b, btn_load_a};
  assign alu.operand1 = operand1;
  assign alu.operand2 = operand2;
  assign alu.op       = op;

  for (genvar b = 0; b < 4; b++) begin : g_btn
    logic [1:0] sync;
    logic       lvl, lvl_q;

    // two-flop synchroniser for the raw asynchronous button
    always_ff @(posedge CLK or posedge RST)
      if (RST) sync <= '0;
      else     sync <= {sync[0], btn_raw[b]};

`ifdef ALU_CONSOLE_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          filt;

    // filtered level flips only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge CLK or posedge RST)
      if (RST) begin
        cnt  <= '0;
        filt <= 1'b0;
      end else if (sync[1] == filt) begin
        cnt  <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt  <= '0;
        filt <= sync[1];
      end else begin
        cnt  <= cnt + 1'b1;
      end

    assign lvl = filt;
`else
    assign lvl = sync[1];
`endif

    // previous level for rising-edge detection: one press, one event
    always_ff @(posedge CLK or posedge RST)
      if (RST) lvl_q <= 1'b0;
      else     lvl_q <= lvl;

    assign ev[b] = lvl & ~lvl_q;
  end

  // operation sequencer; operand loads only accepted while idle, exec wins
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state    <= S_IDLE;
      operand1 <= '0;
      operand2 <= '0;
      op       <= '0;
      result_q <= '0;
      flags_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ev[B_EX]) begin
            state <= S_ISSUE;
            op    <= sw_op;
            busy  <= 1'b1;
          end else if (ev[B_LA]) begin
            operand1 <= DATA_W'({operand1, sw_data});
          end else if (ev[B_LB]) begin
            operand2 <= DATA_W'({operand2, sw_data});
          end
        end
        S_ISSUE: state <= S_CAPTURE;
        S_CAPTURE: begin
          result_q <= alu.alu_result;
          flags_q  <= {alu.alu_negative, alu.alu_overflow, alu.alu_zero};
          done     <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end

  // display page steps 0->1->2->0 regardless of sequencer state
  always_ff @(posedge CLK or posedge RST)
    if (RST)           page <= 2'd0;
    else if (ev[B_PG]) page <= (page == 2'd2) ? 2'd0 : page + 2'd1;

  // value selected for display
  always_comb begin
    sel = result_q;
    case (page)
      2'd1:    sel = operand1;
      2'd2:    sel = operand2;
      default: sel = result_q;
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction

  // registered segment drive; reset shows "0" on every digit
  always_ff @(posedge CLK or posedge RST)
    if (RST) hex <= {DIGITS{7'b1000000}};
    else
      for (int i = 0; i < DIGITS; i++)
        hex[7*i +: 7] <= seg7(sel[4*i +: 4]);

endmodule

// File: doc/alu_console_seq.md
ALU_CONSOLE_SEQ -- requirements
Module: alu_console_seq

Interface
- REQ-001 The block SHALL have parameter DATA_W, default 32, ALU operand/result width; legal values are multiples of 16, 16..32.
- REQ-002 The block SHALL have parameter DIGITS, default 8, number of seven-segment digits driven; legal range 1..DATA_W/4.
- REQ-003 The block SHALL have parameter DEB_CYCLES, default 500000, debounce stability count.
- REQ-004 Port: CLK  in  1  system clock; all state on rising edge.
- REQ-005 Port: RST  in  1  asynchronous active-high reset.
- REQ-006 Port: btn_load_a, btn_load_b, btn_exec, btn_page  in  1 each  raw, asynchronous, active-high buttons.
- REQ-007 Port: sw_data  in  16  switch value for operand entry.
- REQ-008 Port: sw_op  in  4  requested ALU opcode (aluop_t encoding).
- REQ-009 Port: alu_result  in  DATA_W, plus alu_negative, alu_overflow, alu_zero  in  1 each  outputs of the attached combinational ALU.
- REQ-010 Port: operand1, operand2  out  DATA_W, and op  out  4  drive the ALU.
- REQ-011 Port: result_q  out  DATA_W, and flags_q  out  3  {negative, overflow, zero}, both captured.
- REQ-012 Port: busy  out  1; done  out  1  one-cycle pulse.
- REQ-013 Port: page  out  2  current display page; hex  out  7*DIGITS  active-low segments, digit i at bits [7i+6:7i].

Function
- REQ-014 Each button SHALL pass a 2-flop synchroniser followed by a rising-edge detector; one press yields exactly one internal event.
- REQ-015 On a load_a event in IDLE, operand1 SHALL become {operand1[DATA_W-17:0], sw_data} (operand1 = sw_data when DATA_W=16); load_b does the same on operand2.
- REQ-016 The FSM SHALL have states IDLE, ISSUE, CAPTURE and DONE, advancing one state per cycle: IDLE->ISSUE on an exec event; ISSUE->CAPTURE; CAPTURE->DONE; DONE->IDLE.
- REQ-017 On entry to ISSUE, op SHALL latch sw_op, and op SHALL hold until the next exec.
- REQ-018 In CAPTURE, result_q and flags_q SHALL register alu_result and the three flags.
- REQ-019 done SHALL be high exactly in DONE; busy SHALL be high in ISSUE, CAPTURE and DONE.
- REQ-020 Latency from an exec edge event to done SHALL be 3 cycles.
- REQ-021 load_a, load_b and exec events arriving while busy SHALL be dropped, not queued.
- REQ-022 When several events coincide in IDLE, priority SHALL be exec > load_a > load_b, and the lower-priority events are dropped.
- REQ-023 A page event SHALL step page 0->1->2->0 in any FSM state: 0 shows result_q, 1 shows operand1, 2 shows operand2; page value 3 SHALL be unreachable.
- REQ-024 Digit i SHALL show hex nibble [4i+3:4i] of the selected value using the standard active-low 0-F table (0=1000000, 8=0000000, F=0001110).
- REQ-025 hex SHALL be registered, with a 1-cycle delay after its source changes.

Reset
- REQ-026 When RST is asserted, the block SHALL asynchronously force the FSM to IDLE and clear operand1, operand2, op, result_q, flags_q, busy, done, page and all synchroniser and debounce state to 0.
- REQ-027 While RST is asserted, every digit of hex SHALL show 1000000 ("0").
- REQ-028 A reset during ISSUE, CAPTURE or DONE SHALL abort the operation with no done pulse, and result_q SHALL read 0.

Configuration
- REQ-029 When macro ALU_CONSOLE_DEBOUNCE_EN is defined, each synchronised button SHALL feed a counter that updates the filtered level only after DEB_CYCLES consecutive equal samples, and edge detection SHALL use the filtered level.
- REQ-030 When ALU_CONSOLE_DEBOUNCE_EN is undefined, no debounce counters SHALL exist, DEB_CYCLES SHALL be ignored, and edge detection SHALL use the synchroniser output directly.

Verification (DATA_W=32, DIGITS=8, DEB_CYCLES=4, debounce macro defined unless stated)
- REQ-031 Bench SHALL check: sw_data=1234 with load_a, then sw_data=5678 with load_a -> operand1=0x12345678, and page 1 shows 12345678 on hex.
- REQ-032 Bench SHALL check: operand1=5, operand2=3, sw_op=ADD, exec -> done 3 cycles after the edge event, result_q=8, flags_q=000, busy high for 3 cycles.
- REQ-033 Bench SHALL check: a load_b press while busy -> operand2 unchanged; exec and load_a edges in the same cycle -> operation issued and operand1 unchanged.
- REQ-034 Bench SHALL check: a 2-cycle glitch on btn_load_a with the macro defined -> no load; the same glitch with the macro undefined -> one load.
- REQ-035 Bench SHALL check: 4 page presses -> page sequence 1, 2, 0, 1.
- REQ-036 Bench SHALL check: RST asserted in CAPTURE -> next cycle is IDLE with result_q=0, done never asserted, and all hex digits show 1000000.
